// File: rtl/vga_sync_gen.sv
// vga_sync_gen: free-running pixel counters plus delayed VGA sync/enable and frame markers.
module vga_sync_gen #(
    parameter int unsigned H_VISIBLE  = 640,
    parameter int unsigned H_FRONT    = 16,
    parameter int unsigned H_SYNC     = 96,
    parameter int unsigned H_BACK     = 48,
    parameter int unsigned V_VISIBLE  = 480,
    parameter int unsigned V_FRONT    = 10,
    parameter int unsigned V_SYNC     = 2,
    parameter int unsigned V_BACK     = 33,
    parameter int unsigned SYNC_DELAY = 7
) (
    input  logic               clk,
    input  logic               reset,
    output logic signed [31:0] count_h,
    output logic signed [31:0] count_v,
    output logic               vga_hs,
    output logic               vga_vs,
    output logic               vga_de,
    output logic               frame_start,
    output logic [31:0]        frame_count
);

    localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    // One extra code point so the sync-end bound still fits when the back porch is zero.
    localparam int unsigned HW = $clog2(H_TOTAL + 1);
    localparam int unsigned VW = $clog2(V_TOTAL + 1);

    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_VIS    = HW'(H_VISIBLE);
    localparam logic [HW-1:0] HS_START = HW'(H_VISIBLE + H_FRONT);
    localparam logic [HW-1:0] HS_END   = HW'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_VIS    = VW'(V_VISIBLE);
    localparam logic [VW-1:0] VS_START = VW'(V_VISIBLE + V_FRONT);
    localparam logic [VW-1:0] VS_END   = VW'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic          h_wrap, v_wrap;
    logic          de_raw, hs_raw, vs_raw;
    logic          frame_start_q, frame_start_d;
    logic [31:0]   frame_count_q, frame_count_d;
    // Each stage holds {hs, vs, de}; stage SYNC_DELAY-1 drives the pins.
    logic [2:0]    pipe_q [SYNC_DELAY];

    // Counter advance, raw timing decode and frame bookkeeping.
    always_comb begin
        h_wrap        = (h_q == H_LAST);
        v_wrap        = (v_q == V_LAST);
        h_d           = h_wrap ? '0 : h_q + 1'b1;
        v_d           = v_q;
        frame_start_d = 1'b0;
        frame_count_d = frame_count_q;
        if (h_wrap) begin
            v_d = v_wrap ? '0 : v_q + 1'b1;
            if (v_wrap) begin
                frame_start_d = 1'b1;
                frame_count_d = frame_count_q + 32'd1;
            end
        end
        de_raw = (h_q < H_VIS) && (v_q < V_VIS);
        hs_raw = !((h_q >= HS_START) && (h_q < HS_END));
        vs_raw = !((v_q >= VS_START) && (v_q < VS_END));
    end

    // Counter and frame-marker registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_q           <= '0;
            v_q           <= '0;
            frame_start_q <= 1'b0;
            frame_count_q <= '0;
        end else begin
            h_q           <= h_d;
            v_q           <= v_d;
            frame_start_q <= frame_start_d;
            frame_count_q <= frame_count_d;
        end
    end

    // Sync/enable delay line, aligning with the renderer's registered colour.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYNC_DELAY; i++) begin
                pipe_q[i] <= 3'b110;
            end
        end else begin
            pipe_q[0] <= {hs_raw, vs_raw, de_raw};
            for (int i = 1; i < SYNC_DELAY; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign count_h     = 32'(h_q);
    assign count_v     = 32'(v_q);
    assign vga_hs      = pipe_q[SYNC_DELAY-1][2];
    assign vga_vs      = pipe_q[SYNC_DELAY-1][1];
    assign vga_de      = pipe_q[SYNC_DELAY-1][0];
    assign frame_start = frame_start_q;
    assign frame_count = frame_count_q;

endmodule
